// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq
// Consumer end of the PLL lock interface. It synchronizes the raw lock
// signal, waits for the lock to stay stable, and then holds the system
// reset for a fixed number of cycles before it releases the peripherals.
// Lock losses seen while running are counted, and the count saturates.
//
// Optional feature: define PLL_LOSS_FLAG_EN to add a sticky lost_flag
// output and a clear_lost input. When the macro is undefined, neither
// port exists.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_locked,
`ifdef PLL_LOSS_FLAG_EN
  input  logic                 clear_lost,
  output logic                 lost_flag,
`endif
  output logic                 sys_reset,
  output logic                 ready,
  output logic [CNT_WIDTH-1:0] lock_loss_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  // One counter serves both the STABLE window and the HOLD window.
  // It is sized for the longer of the two windows, with a minimum width of 1.
  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(RESET_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic [CNT_WIDTH-1:0]   loss_cnt_q, loss_cnt_d;
  logic                   locked_s;
  logic                   loss_event;

  // Shift the raw lock signal into the synchronizer chain.
  // Nothing else in this module reads the raw lock signal.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
    locked_s = sync_q[SYNC_STAGES-1];
  end

  // Compute the next state and the shared counter.
  // The counter clears on every state change.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    ctr_d      = ctr_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          ctr_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          ctr_d   = '0;
        end else if (ctr_q == STABLE_LAST) begin
          state_d = HOLD;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          ctr_d   = '0;
        end else if (ctr_q == HOLD_LAST) begin
          state_d = RUN;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          ctr_d      = '0;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        ctr_d   = '0;
      end
    endcase
  end

  // Drive sys_reset and ready from the next state, so they change on the
  // same edge as the state does. Count lock losses and stop at all-ones.
  always_comb begin
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    loss_cnt_d  = loss_cnt_q;
    if (loss_event && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Register all state. reset takes priority over every other event.
  always_ff @(posedge clk) begin
    // NOTE: flops take non-blocking assignments so that every flop samples the values from before the edge, whatever order they are listed in.
    if (reset) begin
      sync_q      <= '0;
      state_q     <= WAIT_LOCK;
      ctr_q       <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

`ifdef PLL_LOSS_FLAG_EN
  logic lost_flag_q, lost_flag_d;

  // The sticky loss flag. If a set and a clear arrive in the same cycle,
  // the set wins.
  always_comb begin
    lost_flag_d = lost_flag_q;
    if (loss_event) begin
      lost_flag_d = 1'b1;
    end else if (clear_lost) begin
      lost_flag_d = 1'b0;
    end
  end

  // Register the loss flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lost_flag_q <= 1'b0;
    end else begin
      lost_flag_q <= lost_flag_d;
    end
  end

  assign lost_flag = lost_flag_q;
`endif

  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_cnt_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq
// Directed bench for pll_lock_reset_seq. It uses SYNC_STAGES=2,
// LOCK_STABLE_CYCLES=8 and RESET_HOLD_CYCLES=4, so sys_reset should fall
// 14 edges after the first edge that samples the lock high.
// Two DUTs share the same inputs: one has an 8-bit loss counter and the
// other has a 2-bit loss counter, so saturation can be observed.
// With PLL_LOSS_FLAG_EN defined, the bench also exercises the lost_flag port.
module tb_pll_lock_reset_seq;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       sys_reset, ready;
  logic [7:0] lock_loss_count;
  logic [1:0] state_dbg;
  logic       sat_sys_reset, sat_ready;
  logic [1:0] sat_count;
  logic [1:0] sat_state;
`ifdef PLL_LOSS_FLAG_EN
  logic       clear_lost;
  logic       lost_flag;
  logic       sat_lost_flag;
`endif

  int n_pass;
  int n_total;

  pll_lock_reset_seq #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
`ifdef PLL_LOSS_FLAG_EN
    .clear_lost(clear_lost), .lost_flag(lost_flag),
`endif
    .sys_reset(sys_reset), .ready(ready),
    .lock_loss_count(lock_loss_count), .state_dbg(state_dbg)
  );

  pll_lock_reset_seq #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4), .CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
`ifdef PLL_LOSS_FLAG_EN
    .clear_lost(clear_lost), .lost_flag(sat_lost_flag),
`endif
    .sys_reset(sat_sys_reset), .ready(sat_ready),
    .lock_loss_count(sat_count), .state_dbg(sat_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive the lock high. Edge 0 is the next edge. The helper expects
  // sys_reset=1 at edge 13 and RUN at edge 14.
  task automatic relock_to_run(input string tag);
    pll_locked = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      if (e == 13) cmp({tag, " sys_reset@13"}, int'(sys_reset), 1);
      if (e == 14) begin
        cmp({tag, " sys_reset@14"}, int'(sys_reset), 0);
        cmp({tag, " ready@14"}, int'(ready), 1);
        cmp({tag, " state@14"}, int'(state_dbg), 3);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    pll_locked = 1'b1;
    tick();
    tick();
    cmp("reset sys_reset", int'(sys_reset), 1);
    cmp("reset ready", int'(ready), 0);
    cmp("reset count", int'(lock_loss_count), 0);
    cmp("reset state", int'(state_dbg), 0);
    cmp("reset sat count", int'(sat_count), 0);
`ifdef PLL_LOSS_FLAG_EN
    cmp("reset lost_flag", int'(lost_flag), 0);
`endif
    pll_locked = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Check the state and sys_reset on every edge of the first lock sequence.
  task automatic test_lock_sequence();
    int exp_state;
    pll_locked = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      tick();
      exp_state = (e < 2) ? 0 : (e < 10) ? 1 : (e < 14) ? 2 : 3;
      cmp($sformatf("seq state@%0d", e), int'(state_dbg), exp_state);
      cmp($sformatf("seq sys_reset@%0d", e), int'(sys_reset), (e < 14) ? 1 : 0);
      cmp($sformatf("seq ready@%0d", e), int'(ready), (e < 14) ? 0 : 1);
    end
  endtask

  task automatic test_glitch();
    reset      = 1'b1;
    pll_locked = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (5) tick();         // edges 0..4
    pll_locked = 1'b0;
    tick();                    // edge 5
    tick();                    // edge 6
    cmp("glitch state@6", int'(state_dbg), 1);
    tick();                    // edge 7
    cmp("glitch state@7", int'(state_dbg), 0);
    repeat (3) tick();
    cmp("glitch sys_reset", int'(sys_reset), 1);
    cmp("glitch count", int'(lock_loss_count), 0);
    relock_to_run("glitch relock");
    cmp("glitch count after relock", int'(lock_loss_count), 0);
  endtask

  task automatic test_run_loss();
    pll_locked = 1'b0;
    tick();                    // edge j
    cmp("loss sys_reset@j", int'(sys_reset), 0);
    tick();                    // edge j+1
    cmp("loss sys_reset@j+1", int'(sys_reset), 0);
    cmp("loss state@j+1", int'(state_dbg), 3);
    tick();                    // edge j+2
    cmp("loss sys_reset@j+2", int'(sys_reset), 1);
    cmp("loss ready@j+2", int'(ready), 0);
    cmp("loss state@j+2", int'(state_dbg), 0);
    cmp("loss count", int'(lock_loss_count), 1);
    cmp("loss sat count", int'(sat_count), 1);
    relock_to_run("loss relock");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) relock_to_run("sat relock");
      pll_locked = 1'b0;
      repeat (3) tick();
      cmp($sformatf("sat count loss%0d", i), int'(sat_count), (2 + i > 3) ? 3 : 2 + i);
    end
    cmp("wide count after 6 losses", int'(lock_loss_count), 6);
  endtask

  task automatic test_reset_priority();
    pll_locked = 1'b1;
    repeat (11) tick();        // edges 0..10; HOLD is entered at edge 10
    cmp("prio in HOLD", int'(state_dbg), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("prio hold state", int'(state_dbg), 0);
    cmp("prio hold sys_reset", int'(sys_reset), 1);
    cmp("prio hold count", int'(lock_loss_count), 0);
    cmp("prio hold sat count", int'(sat_count), 0);
    relock_to_run("prio relock");
    pll_locked = 1'b0;
    tick();                    // edge j
    tick();                    // edge j+1
    reset = 1'b1;
    tick();                    // edge j+2: the loss and the reset coincide
    reset = 1'b0;
    cmp("prio loss state", int'(state_dbg), 0);
    cmp("prio loss sys_reset", int'(sys_reset), 1);
    cmp("prio loss count", int'(lock_loss_count), 0);
`ifdef PLL_LOSS_FLAG_EN
    cmp("prio loss lost_flag", int'(lost_flag), 0);
`endif
    tick();
    cmp("prio loss count later", int'(lock_loss_count), 0);
  endtask

`ifdef PLL_LOSS_FLAG_EN
  task automatic test_lost_flag();
    relock_to_run("flag relock");
    cmp("flag idle", int'(lost_flag), 0);
    pll_locked = 1'b0;
    repeat (3) tick();
    cmp("flag set", int'(lost_flag), 1);
    relock_to_run("flag relock2");
    cmp("flag persists", int'(lost_flag), 1);
    clear_lost = 1'b1;
    tick();
    clear_lost = 1'b0;
    cmp("flag cleared", int'(lost_flag), 0);
    pll_locked = 1'b0;
    tick();
    tick();
    clear_lost = 1'b1;
    tick();                    // a loss event and a clear in the same cycle
    clear_lost = 1'b0;
    cmp("flag set beats clear", int'(lost_flag), 1);
    cmp("flag count", int'(lock_loss_count), 2);
  endtask
`endif

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset      = 1'b1;
    pll_locked = 1'b0;
`ifdef PLL_LOSS_FLAG_EN
    clear_lost = 1'b0;
`endif
    test_reset();
    test_lock_sequence();
    test_glitch();
    test_run_loss();
    test_saturation();
    test_reset_priority();
`ifdef PLL_LOSS_FLAG_EN
    test_lost_flag();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
